// File: rtl/prio_coder_rr.sv
// Registered priority encoder / arbiter: fixed-priority (highest index wins) or
// round-robin from a pointer, with a valid/ack hold so a grant stays put until taken.
module prio_coder_rr #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         mode,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         multi
);

  logic [W-1:0] code_q, code_d;
  logic [N-1:0] grant_q, grant_d;
  logic         valid_q, valid_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_upper_idx;
  logic         rr_upper_found;
  logic [W-1:0] rr_low_idx;
  logic [W-1:0] sel_idx;
  logic         req_any;
  logic         req_multi;
  logic         sample;

  // Fixed priority: scanning upward, the last set bit seen is the highest index.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_idx = W'(i);
    end
  end

  // Round robin: lowest set index above ptr if any, otherwise the lowest set
  // index overall (which wraps past N-1 to 0 and may land on ptr itself).
  always_comb begin
    rr_upper_idx   = '0;
    rr_upper_found = 1'b0;
    rr_low_idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        rr_low_idx = W'(i);
        if (i > int'(ptr_q)) begin
          rr_upper_idx   = W'(i);
          rr_upper_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_any   = |req;
    req_multi = (req & (req - N'(1))) != '0;
    sample    = en && (!valid_q || ack);
    if (mode) sel_idx = rr_upper_found ? rr_upper_idx : rr_low_idx;
    else      sel_idx = fix_idx;
  end

  always_comb begin
    code_d  = code_q;
    grant_d = grant_q;
    valid_d = valid_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (sample) begin
      if (req_any) begin
        code_d  = sel_idx;
        valid_d = 1'b1;
        multi_d = req_multi;
        ptr_d   = sel_idx;
        for (int i = 0; i < N; i++) begin
          grant_d[i] = (sel_idx == W'(i));
        end
      end else begin
        valid_d = 1'b0;
        grant_d = '0;
        multi_d = 1'b0;
      end
    end else if (ack && !en) begin
      // Consumer took the grant but sampling is off: retire it, take nothing new.
      valid_d = 1'b0;
      grant_d = '0;
      multi_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else begin
      code_q  <= code_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign code  = code_q;
  assign grant = grant_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_prio_coder_rr.sv
// Directed bench for prio_coder_rr: vector table for N=8 fixed priority, plus
// hand sequences for round robin, stall, async reset and an N=5 wrap.
module tb_prio_coder_rr;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       en, mode, ack;
  logic [2:0] code;
  logic [7:0] grant;
  logic       valid, multi;

  logic [4:0] req5;
  logic       en5, mode5, ack5;
  logic [2:0] code5;
  logic [4:0] grant5;
  logic       valid5, multi5;

  int checks = 0;
  int failures = 0;

  prio_coder_rr #(.N(8), .W(3)) dut8 (
    .clk(clk), .rst(rst), .req(req), .en(en), .mode(mode), .ack(ack),
    .code(code), .grant(grant), .valid(valid), .multi(multi)
  );

  prio_coder_rr #(.N(5), .W(3)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .en(en5), .mode(mode5), .ack(ack5),
    .code(code5), .grant(grant5), .valid(valid5), .multi(multi5)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       en;
    logic       ack;
    logic       ev;
    logic [2:0] ec;
    logic [7:0] eg;
    logic       em;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic ev, input logic [2:0] ec,
                      input logic [7:0] eg, input logic em);
    chk({tag, ".valid"}, 64'(valid), 64'(ev));
    chk({tag, ".code"},  64'(code),  64'(ec));
    chk({tag, ".grant"}, 64'(grant), 64'(eg));
    chk({tag, ".multi"}, 64'(multi), 64'(em));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{8'(1 << i), 1'b0, 1'b1, 1'b1, 1'b1, 3'(i), 8'(1 << i), 1'b0};
    end
    tbl[8]  = '{8'b1000_0101, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[9]  = '{8'h00,        1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
    tbl[10] = '{8'h06,        1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04, 1'b1};
    tbl[11] = '{8'h01,        1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1};
    tbl[12] = '{8'h01,        1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
    tbl[13] = '{8'h01,        1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};

    rst = 1'b1;
    req = '0; en = 1'b0; mode = 1'b0; ack = 1'b0;
    req5 = '0; en5 = 1'b0; mode5 = 1'b0; ack5 = 1'b0;
    #15;
    chk8("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;

    // Fixed priority table
    for (int v = 0; v < 14; v++) begin
      req  = tbl[v].req;
      mode = tbl[v].mode;
      en   = tbl[v].en;
      ack  = tbl[v].ack;
      tick();
      chk8($sformatf("vec%0d", v), tbl[v].ev, tbl[v].ec, tbl[v].eg, tbl[v].em);
    end

    // Round robin from reset with req held at 1000_0101: 0, 2, 7, 0
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mode = 1'b1; req = 8'b1000_0101; en = 1'b1; ack = 1'b1;
    tick(); chk8("rr0", 1'b1, 3'd0, 8'h01, 1'b1);
    tick(); chk8("rr1", 1'b1, 3'd2, 8'h04, 1'b1);
    tick(); chk8("rr2", 1'b1, 3'd7, 8'h80, 1'b1);
    tick(); chk8("rr3", 1'b1, 3'd0, 8'h01, 1'b1);
    tick(); chk8("rr4", 1'b1, 3'd2, 8'h04, 1'b1);

    // Stall on code 2 while req moves to 0x80
    ack = 1'b0; req = 8'h80;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk8($sformatf("stall%0d", c), 1'b1, 3'd2, 8'h04, 1'b1);
    end
    ack = 1'b1;
    tick(); chk8("stall_rel", 1'b1, 3'd7, 8'h80, 1'b0);

    // Async reset mid-stall
    ack = 1'b0; req = 8'h05;
    tick(); chk8("pre_rst", 1'b1, 3'd7, 8'h80, 1'b0);
    #5;
    rst = 1'b1;
    #1;
    chk8("async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    #2;
    rst = 1'b0;
    mode = 1'b1; req = 8'hFF; ack = 1'b1; en = 1'b1;
    tick(); chk8("post_rst", 1'b1, 3'd0, 8'h01, 1'b1);
    tick(); chk8("post_rst2", 1'b1, 3'd1, 8'h02, 1'b1);

    // N=5 round robin wrap: 0, 4, 0, 4
    en = 1'b0;
    mode5 = 1'b1; req5 = 5'b10001; en5 = 1'b1; ack5 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("n5_%0d.code", c),  64'(code5),  (c % 2 == 0) ? 64'd0 : 64'd4);
      chk($sformatf("n5_%0d.grant", c), 64'(grant5), (c % 2 == 0) ? 64'h01 : 64'h10);
      chk($sformatf("n5_%0d.valid", c), 64'(valid5), 64'd1);
      chk($sformatf("n5_%0d.multi", c), 64'(multi5), 64'd1);
    end
    // Lone requester equal to ptr wins again
    req5 = 5'b10000;
    tick();
    chk("n5_same.code",  64'(code5),  64'd4);
    chk("n5_same.multi", 64'(multi5), 64'd0);
    tick();
    chk("n5_same2.code", 64'(code5),  64'd4);
    chk("n5_same2.valid", 64'(valid5), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
